// File: rtl/alu_seq_core.sv
// -----------------------------------------------------------------------------
// alu_seq_core
//
// Handshaked multi-cycle ALU. A request (a, b, op) is accepted in IDLE when
// in_valid && in_ready. Single-cycle ops register their result and go
// straight to DONE. MUL runs a shift-add loop, one multiplier bit per cycle
// (LSB first), for DATA_WIDTH cycles. The result is then held in DONE until
// the consumer takes it with out_ready. Only one operation is in flight at a
// time. in_ready is low outside IDLE.
//
// Optional feature macro: ALU_SEQ_ILLEGAL_OP_EN
//   defined   : opcodes 6/7 return out=0 with err=1
//   undefined : err tied low; opcodes 6/7 return out=0 silently
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request present
//   in_ready   out  core can accept a request (IDLE only)
//   a, b       in   DATA_WIDTH operands, treated as unsigned
//   op         in   alu_pkg::OP_WIDTH opcode
//   out_valid  out  result present (DONE)
//   out_ready  in   consumer accepts the result
//   out        out  OUT_WIDTH result
//   err        out  illegal-opcode flag, qualified by out_valid
// -----------------------------------------------------------------------------

package alu_pkg;
    localparam int OP_WIDTH = 3;

    localparam logic [OP_WIDTH-1:0] OP_ADD = 3'd0;
    localparam logic [OP_WIDTH-1:0] OP_SUB = 3'd1;
    localparam logic [OP_WIDTH-1:0] OP_MUL = 3'd2;
    localparam logic [OP_WIDTH-1:0] OP_AND = 3'd3;
    localparam logic [OP_WIDTH-1:0] OP_OR  = 3'd4;
    localparam logic [OP_WIDTH-1:0] OP_XOR = 3'd5;
endpackage

module alu_seq_core #(
    parameter  int DATA_WIDTH = 8,
    localparam int OUT_WIDTH  = 2 * DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        a,
    input  logic [DATA_WIDTH-1:0]        b,
    input  logic [alu_pkg::OP_WIDTH-1:0] op,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_WIDTH-1:0]         out,
    output logic                         err
);
    import alu_pkg::*;

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;

    logic [OUT_WIDTH-1:0]   result_reg;    // single-cycle result, or MUL accumulator
    logic [OUT_WIDTH-1:0]   mcand_reg;     // multiplicand, shifted left each iteration
    logic [DATA_WIDTH-1:0]  mplier_reg;    // multiplier, shifted right each iteration
    logic [CNT_W-1:0]       count_reg;

    logic                   accept;
    logic                   last_iter;

    logic [OUT_WIDTH-1:0]   a_ext;
    logic [OUT_WIDTH-1:0]   b_ext;
    logic [DATA_WIDTH-1:0]  and_bits;
    logic [DATA_WIDTH-1:0]  or_bits;
    logic [DATA_WIDTH-1:0]  xor_bits;
    logic [OUT_WIDTH-1:0]   sc_result;
    logic                   sc_illegal;

    assign accept    = in_valid && (state_reg == S_IDLE);
    assign last_iter = (count_reg == CNT_W'(DATA_WIDTH - 1));

    assign a_ext = {{DATA_WIDTH{1'b0}}, a};
    assign b_ext = {{DATA_WIDTH{1'b0}}, b};

    // Bitwise unit, one slice per operand bit
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_bitwise
            assign and_bits[gi] = a[gi] & b[gi];
            assign or_bits[gi]  = a[gi] | b[gi];
            assign xor_bits[gi] = a[gi] ^ b[gi];
        end
    endgenerate

    // Single-cycle datapath. Operands are zero-extended, so ADD's carry lands
    // in bit DATA_WIDTH and SUB wraps modulo 2^OUT_WIDTH.
    always_comb begin
        sc_result  = '0;
        sc_illegal = 1'b0;
        case (op)
            OP_ADD:  sc_result = a_ext + b_ext;
            OP_SUB:  sc_result = a_ext - b_ext;
            OP_MUL:  sc_result = '0;
            OP_AND:  sc_result = {{DATA_WIDTH{1'b0}}, and_bits};
            OP_OR:   sc_result = {{DATA_WIDTH{1'b0}}, or_bits};
            OP_XOR:  sc_result = {{DATA_WIDTH{1'b0}}, xor_bits};
            default: sc_illegal = 1'b1;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next = (op == OP_MUL) ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (last_iter) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_reg)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            result_reg <= '0;
                            mcand_reg  <= a_ext;
                            mplier_reg <= b;
                            count_reg  <= '0;
                        end else begin
                            result_reg <= sc_illegal ? '0 : sc_result;
                        end
                    end
                end
                S_MUL: begin
                    // The final iteration also accumulates; the FSM moves to
                    // DONE on the same edge, so the product is complete there.
                    if (mplier_reg[0]) begin
                        result_reg <= result_reg + mcand_reg;
                    end
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    count_reg  <= count_reg + 1'b1;
                end
                default: ;  // DONE holds the result stable
            endcase
        end
    end

    assign out = result_reg;

`ifdef ALU_SEQ_ILLEGAL_OP_EN
    logic err_reg;

    // err is captured at accept time; MUL is always a legal op so it clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (accept) begin
            err_reg <= sc_illegal;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_core.sv
module tb_alu_seq_core;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_out;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [15:0] out;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[13];

`ifdef ALU_SEQ_ILLEGAL_OP_EN
    localparam logic ILL_ERR = 1'b1;
`else
    localparam logic ILL_ERR = 1'b0;
`endif

    alu_seq_core #(.DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Issue one request with out_ready held high, check latency, result and
    // the handoff back to IDLE.
    task automatic run_op(input string name, input logic [2:0] o, input logic [7:0] x,
                          input logic [7:0] y, input logic [15:0] eo, input logic ee,
                          input int el);
        exp_t e;
        int   cyc;
        bit   busy_ready;
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
        e.out = eo; e.err = ee;
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'h5A; b = 8'hA5; op = 3'd0;
        cyc = 1; busy_ready = 1'b0;
        while (!out_valid && cyc < 50) begin
            if (in_ready) busy_ready = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, "_latency"}, 32'(cyc), 32'(el));
        chk({name, "_busy_in_ready"}, 32'(busy_ready), 32'd0);
        e = exp_q.pop_front();
        if (out_valid) begin
            chk({name, "_done_in_ready"}, 32'(in_ready), 32'd0);
            chk({name, "_out"}, 32'(out), 32'(e.out));
            chk({name, "_err"}, 32'(err), 32'(e.err));
        end
        $display("txn %s op=%0d a=0x%02h b=0x%02h out=0x%04h err=%0b lat=%0d",
                 name, o, x, y, out, err, cyc);
        @(posedge clk); #1;
        chk({name, "_handoff_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_handoff_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        exp_t e;
        bit   stale;

        vecs[0]  = '{"add_200_100",  3'd0, 8'd200, 8'd100, 16'h012C, 1'b0, 1};
        vecs[1]  = '{"sub_5_7",      3'd1, 8'd5,   8'd7,   16'hFFFE, 1'b0, 1};
        vecs[2]  = '{"and_f0_3c",    3'd3, 8'hF0,  8'h3C,  16'h0030, 1'b0, 1};
        vecs[3]  = '{"xor_ff_0f",    3'd5, 8'hFF,  8'h0F,  16'h00F0, 1'b0, 1};
        vecs[4]  = '{"or_a0_05",     3'd4, 8'hA0,  8'h05,  16'h00A5, 1'b0, 1};
        vecs[5]  = '{"mul_255_255",  3'd2, 8'd255, 8'd255, 16'hFE01, 1'b0, 9};
        vecs[6]  = '{"mul_13_11",    3'd2, 8'd13,  8'd11,  16'h008F, 1'b0, 9};
        vecs[7]  = '{"mul_0_200",    3'd2, 8'd0,   8'd200, 16'h0000, 1'b0, 9};
        vecs[8]  = '{"add_255_255",  3'd0, 8'd255, 8'd255, 16'h01FE, 1'b0, 1};
        vecs[9]  = '{"sub_0_1",      3'd1, 8'd0,   8'd1,   16'hFFFF, 1'b0, 1};
        vecs[10] = '{"illegal_op7",  3'd7, 8'd1,   8'd1,   16'h0000, ILL_ERR, 1};
        vecs[11] = '{"illegal_op6",  3'd6, 8'hFF,  8'hFF,  16'h0000, ILL_ERR, 1};
        vecs[12] = '{"add_after_ill",3'd0, 8'd1,   8'd2,   16'h0003, 1'b0, 1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op = '0;
        #1;
        chk("reset_in_ready",  32'(in_ready),  32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out",       32'(out),       32'd0);
        chk("reset_err",       32'(err),       32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_out, vecs[i].exp_err, vecs[i].exp_lat);
        end

        // Backpressure: result held for 5 stalled cycles, second request ignored
        @(negedge clk);
        out_ready = 1'b0;
        op = 3'd0; a = 8'd1; b = 8'd1; in_valid = 1'b1;
        e.out = 16'h0002; e.err = 1'b0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        op = 3'd0; a = 8'd9; b = 8'd9; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d_out_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d_out", k),       32'(out),       32'(exp_q[0].out));
            chk($sformatf("stall%0d_in_ready", k),  32'(in_ready),  32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        e = exp_q.pop_front();
        chk("stall_final_out", 32'(out), 32'(e.out));
        $display("txn backpressure_add_1_1 out=0x%04h err=%0b", out, err);
        @(posedge clk); #1;
        chk("stall_handoff_valid", 32'(out_valid), 32'd0);
        chk("stall_handoff_ready", 32'(in_ready),  32'd1);
        stale = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        chk("stall_second_req_ignored", 32'(stale), 32'd0);

        // Reset in MUL cycle 4 of 3x4
        @(negedge clk);
        op = 3'd2; a = 8'd3; b = 8'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("mid_mul_in_ready_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_mul_reset_in_ready",  32'(in_ready),  32'd1);
        chk("mid_mul_reset_out_valid", 32'(out_valid), 32'd0);
        chk("mid_mul_reset_out",       32'(out),       32'd0);
        $display("txn mul_3_4_aborted_by_reset in_ready=%0b out_valid=%0b", in_ready, out_valid);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("add_2_3_after_reset", 3'd0, 8'd2, 8'd3, 16'h0005, 1'b0, 1);
        stale = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        chk("no_stale_product", 32'(stale), 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
